// File: rtl/keypad_scan_decode.sv
// keypad_scan_decode
//   Drives a 4x4 keypad one row at a time and decodes debounced presses into
//   key codes.  Digit keys are collected into a three-digit BCD entry buffer:
//   '*' clears the buffer and '#' commits it to num_value.
//
// Ports
//   clk          system clock, rising edge
//   n_reset      asynchronous active-low reset
//   db_pulse     debounced press level; high for the hold window of a press
//   col_latched  column captured by the debouncer, active-high, bit0 = leftmost
//   row_out      row drive, one-hot active-low, bit0 = top row
//   key_valid    one-cycle strobe, key_code valid
//   key_code     decoded key (0-9, A-D, '*'=E, '#'=F), held until next key
//   digits       BCD entry buffer, digits[11:8] oldest
//   num_valid    one-cycle strobe when '#' commits the buffer
//   num_value    committed BCD value, held until next commit
//   err          one-cycle strobe on bad column pattern or buffer overflow
//
// state   | meaning
// SCAN    | divider runs, rows step; waiting for a press edge
// CAPTURE | decode the frozen row with the latched column
// EMIT    | key_valid / num_valid / err strobes are visible
// HOLD    | row frozen until db_pulse drops
module keypad_scan_decode #(
  parameter int unsigned SCAN_DIV = 27_000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        db_pulse,
  input  logic [3:0]  col_latched,
  output logic [3:0]  row_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [11:0] digits,
  output logic        num_valid,
  output logic [11:0] num_value,
  output logic        err
);

  localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

  localparam logic [3:0] CODE_STAR = 4'hE;
  localparam logic [3:0] CODE_HASH = 4'hF;

  typedef enum logic [1:0] {SCAN, CAPTURE, EMIT, HOLD} state_t;

  state_t      state, state_nxt;
  logic [19:0] div_cnt;
  logic [1:0]  row_idx;
  logic [1:0]  dig_count;
  logic        db_q;
  logic        db_rise;

  logic        col_onehot;
  logic [1:0]  col_idx;
  logic [3:0]  code_dec;

  assign db_rise = db_pulse & ~db_q;
  assign row_out = ~(4'b0001 << row_idx);

  always_comb begin
    col_onehot = 1'b1;
    col_idx    = 2'd0;
    case (col_latched)
      4'b0001: col_idx = 2'd0;
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_onehot = 1'b0;
    endcase
  end

  always_comb begin
    code_dec = 4'h0;
    case ({row_idx, col_idx})
      4'b00_00: code_dec = 4'h1;
      4'b00_01: code_dec = 4'h2;
      4'b00_10: code_dec = 4'h3;
      4'b00_11: code_dec = 4'hA;
      4'b01_00: code_dec = 4'h4;
      4'b01_01: code_dec = 4'h5;
      4'b01_10: code_dec = 4'h6;
      4'b01_11: code_dec = 4'hB;
      4'b10_00: code_dec = 4'h7;
      4'b10_01: code_dec = 4'h8;
      4'b10_10: code_dec = 4'h9;
      4'b10_11: code_dec = 4'hC;
      4'b11_00: code_dec = CODE_STAR;
      4'b11_01: code_dec = 4'h0;
      4'b11_10: code_dec = CODE_HASH;
      4'b11_11: code_dec = 4'hD;
      default:  code_dec = 4'h0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= SCAN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:    if (db_rise) state_nxt = CAPTURE;
      CAPTURE: state_nxt = col_onehot ? EMIT : HOLD;
      EMIT:    state_nxt = HOLD;
      HOLD:    if (!db_pulse) state_nxt = SCAN;
      default: state_nxt = SCAN;
    endcase
  end

  // Reset db_q high so a press level already present at reset release is
  // not mistaken for a new edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) db_q <= 1'b1;
    else          db_q <= db_pulse;
  end

  // The divider only runs in SCAN and not on the edge that starts a capture,
  // so the decoded row is the one that was being driven when the press came.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      div_cnt <= '0;
      row_idx <= 2'd0;
    end else if (state == SCAN && !db_rise) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        row_idx <= row_idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + 20'd1;
      end
    end
  end

  // All key actions are registered on the CAPTURE edge, so strobes and the
  // updated buffer are visible during the following cycle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      digits    <= 12'h000;
      dig_count <= 2'd0;
      num_valid <= 1'b0;
      num_value <= 12'h000;
      err       <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      num_valid <= 1'b0;
      err       <= 1'b0;
      if (state == CAPTURE) begin
        if (col_onehot) begin
          key_valid <= 1'b1;
          key_code  <= code_dec;
          if (code_dec <= 4'h9) begin
            if (dig_count < 2'd3) begin
              digits    <= {digits[7:0], code_dec};
              dig_count <= dig_count + 2'd1;
            end else begin
              err <= 1'b1;
            end
          end else if (code_dec == CODE_STAR) begin
            digits    <= 12'h000;
            dig_count <= 2'd0;
          end else if (code_dec == CODE_HASH) begin
            num_value <= digits;
            num_valid <= 1'b1;
            digits    <= 12'h000;
            dig_count <= 2'd0;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_decode.sv
module tb_keypad_scan_decode;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        db_pulse = 1'b0;
  logic [3:0]  col_latched = 4'h0;
  logic [3:0]  row_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] digits;
  logic        num_valid;
  logic [11:0] num_value;
  logic        err;

  int total = 0;
  int bad = 0;

  keypad_scan_decode #(.SCAN_DIV(4)) dut (
    .clk(clk), .n_reset(n_reset), .db_pulse(db_pulse), .col_latched(col_latched),
    .row_out(row_out), .key_valid(key_valid), .key_code(key_code), .digits(digits),
    .num_valid(num_valid), .num_value(num_value), .err(err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    n_reset = 1'b0;
    db_pulse = 1'b0;
    col_latched = 4'h0;
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
  endtask

  // Waits for the requested row, presses, and samples strobes one cycle
  // after the edge (early) and two cycles after the edge (strobe cycle).
  task automatic press(input logic [1:0] row, input logic [3:0] col, input bit release_after,
                       output bit ok, output logic e_kv, output logic e_err,
                       output logic kv, output logic er, output logic nv);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (row_out == ~(4'b0001 << row)) begin
        ok = 1'b1;
        break;
      end
    end
    col_latched = col;
    db_pulse = 1'b1;
    @(posedge clk); #1;
    e_kv = key_valid; e_err = err;
    @(posedge clk); #1;
    kv = key_valid; er = err; nv = num_valid;
    if (release_after) begin
      @(posedge clk); #1;
      db_pulse = 1'b0;
      col_latched = 4'h0;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bit strobe_seen;
    n_reset = 1'b0;
    db_pulse = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (row_out !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 || digits !== 12'h000 ||
        num_valid !== 1'b0 || num_value !== 12'h000 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_values got row=%b kv=%b code=%h dig=%h nv=%b nval=%h err=%b want row=1110 rest 0",
               row_out, key_valid, key_code, digits, num_valid, num_value, err);
    end
    n_reset = 1'b1;
    strobe_seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (key_valid || err || num_valid) strobe_seen = 1'b1;
    end
    total++;
    if (strobe_seen !== 1'b0) begin
      bad++;
      $display("FAIL held_press_at_release got strobe=%b want 0", strobe_seen);
    end
    db_pulse = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_row_scan();
    logic [3:0] exp_row;
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      exp_row = ~(4'b0001 << ((i / 4) % 4));
      total++;
      if (row_out !== exp_row) begin
        bad++;
        $display("FAIL row_scan[%0d] got=%b want=%b", i, row_out, exp_row);
      end
    end
  endtask

  task automatic test_single_key();
    bit ok; logic e_kv, e_err, kv, er, nv;
    do_reset();
    press(2'd1, 4'b0100, 1'b1, ok, e_kv, e_err, kv, er, nv);
    total++;
    if (!ok || e_kv !== 1'b0) begin
      bad++;
      $display("FAIL key6_latency ok=%b early_kv=%b want ok=1 early_kv=0", ok, e_kv);
    end
    total++;
    if (kv !== 1'b1 || er !== 1'b0 || nv !== 1'b0) begin
      bad++;
      $display("FAIL key6_strobe got kv=%b err=%b nv=%b want 1 0 0", kv, er, nv);
    end
    total++;
    if (key_code !== 4'h6 || digits !== 12'h006) begin
      bad++;
      $display("FAIL key6_value got code=%h dig=%h want 6 006", key_code, digits);
    end
  endtask

  task automatic test_overflow();
    bit ok; logic e_kv, e_err, kv, er, nv;
    do_reset();
    press(2'd0, 4'b0001, 1'b1, ok, e_kv, e_err, kv, er, nv);
    press(2'd0, 4'b0010, 1'b1, ok, e_kv, e_err, kv, er, nv);
    press(2'd0, 4'b0100, 1'b1, ok, e_kv, e_err, kv, er, nv);
    total++;
    if (digits !== 12'h123 || kv !== 1'b1 || er !== 1'b0) begin
      bad++;
      $display("FAIL digits_123 got dig=%h kv=%b err=%b want 123 1 0", digits, kv, er);
    end
    press(2'd1, 4'b0001, 1'b1, ok, e_kv, e_err, kv, er, nv);
    total++;
    if (kv !== 1'b1 || er !== 1'b1 || e_err !== 1'b0) begin
      bad++;
      $display("FAIL overflow_strobe got kv=%b err=%b early_err=%b want 1 1 0", kv, er, e_err);
    end
    total++;
    if (digits !== 12'h123 || key_code !== 4'h4) begin
      bad++;
      $display("FAIL overflow_hold got dig=%h code=%h want 123 4", digits, key_code);
    end
  endtask

  task automatic test_number();
    bit ok; logic e_kv, e_err, kv, er, nv;
    do_reset();
    press(2'd1, 4'b0001, 1'b1, ok, e_kv, e_err, kv, er, nv);
    press(2'd1, 4'b0010, 1'b1, ok, e_kv, e_err, kv, er, nv);
    press(2'd3, 4'b0100, 1'b1, ok, e_kv, e_err, kv, er, nv);
    total++;
    if (kv !== 1'b1 || nv !== 1'b1 || er !== 1'b0 || key_code !== 4'hF) begin
      bad++;
      $display("FAIL hash_strobe got kv=%b nv=%b err=%b code=%h want 1 1 0 F", kv, nv, er, key_code);
    end
    total++;
    if (num_value !== 12'h045 || digits !== 12'h000) begin
      bad++;
      $display("FAIL hash_value got nval=%h dig=%h want 045 000", num_value, digits);
    end
    press(2'd3, 4'b0001, 1'b1, ok, e_kv, e_err, kv, er, nv);
    total++;
    if (kv !== 1'b1 || nv !== 1'b0 || key_code !== 4'hE || digits !== 12'h000 || num_value !== 12'h045) begin
      bad++;
      $display("FAIL star got kv=%b nv=%b code=%h dig=%h nval=%h want 1 0 E 000 045",
               kv, nv, key_code, digits, num_value);
    end
    press(2'd2, 4'b0001, 1'b1, ok, e_kv, e_err, kv, er, nv);
    press(2'd0, 4'b1000, 1'b1, ok, e_kv, e_err, kv, er, nv);
    total++;
    if (kv !== 1'b1 || er !== 1'b0 || nv !== 1'b0 || key_code !== 4'hA || digits !== 12'h007 ||
        num_value !== 12'h045) begin
      bad++;
      $display("FAIL letter_a got kv=%b err=%b nv=%b code=%h dig=%h nval=%h want 1 0 0 A 007 045",
               kv, er, nv, key_code, digits, num_value);
    end
    press(2'd3, 4'b0001, 1'b1, ok, e_kv, e_err, kv, er, nv);
    press(2'd3, 4'b0100, 1'b1, ok, e_kv, e_err, kv, er, nv);
    total++;
    if (nv !== 1'b1 || num_value !== 12'h000) begin
      bad++;
      $display("FAIL hash_empty got nv=%b nval=%h want 1 000", nv, num_value);
    end
  endtask

  task automatic test_bad_decode();
    bit ok; bit moved; logic e_kv, e_err, kv, er, nv;
    logic [3:0] row_before;
    do_reset();
    press(2'd2, 4'b0001, 1'b1, ok, e_kv, e_err, kv, er, nv);
    press(2'd2, 4'b0110, 1'b1, ok, e_kv, e_err, kv, er, nv);
    total++;
    if (er !== 1'b1 || kv !== 1'b0 || e_err !== 1'b0) begin
      bad++;
      $display("FAIL bad_col got err=%b kv=%b early_err=%b want 1 0 0", er, kv, e_err);
    end
    total++;
    if (digits !== 12'h007 || key_code !== 4'h7) begin
      bad++;
      $display("FAIL bad_col_state got dig=%h code=%h want 007 7", digits, key_code);
    end
    row_before = row_out;
    moved = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (row_out !== row_before) begin
        moved = 1'b1;
        break;
      end
    end
    total++;
    if (moved !== 1'b1) begin
      bad++;
      $display("FAIL back_to_scan got row_moved=%b want 1", moved);
    end
    press(2'd0, 4'b0000, 1'b1, ok, e_kv, e_err, kv, er, nv);
    total++;
    if (er !== 1'b1 || kv !== 1'b0) begin
      bad++;
      $display("FAIL no_col got err=%b kv=%b want 1 0", er, kv);
    end
  endtask

  task automatic test_reset_in_hold();
    bit ok; bit strobe_seen; logic e_kv, e_err, kv, er, nv;
    do_reset();
    press(2'd0, 4'b0001, 1'b1, ok, e_kv, e_err, kv, er, nv);
    press(2'd0, 4'b0010, 1'b1, ok, e_kv, e_err, kv, er, nv);
    press(2'd0, 4'b1000, 1'b0, ok, e_kv, e_err, kv, er, nv);
    @(posedge clk); #1;
    total++;
    if (digits !== 12'h012 || key_code !== 4'hA) begin
      bad++;
      $display("FAIL pre_reset got dig=%h code=%h want 012 A", digits, key_code);
    end
    n_reset = 1'b0;
    #1;
    total++;
    if (row_out !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 || digits !== 12'h000 ||
        num_valid !== 1'b0 || num_value !== 12'h000 || err !== 1'b0) begin
      bad++;
      $display("FAIL hold_reset got row=%b kv=%b code=%h dig=%h nv=%b nval=%h err=%b want row=1110 rest 0",
               row_out, key_valid, key_code, digits, num_valid, num_value, err);
    end
    db_pulse = 1'b0;
    col_latched = 4'h0;
    @(posedge clk); #1;
    n_reset = 1'b1;
    strobe_seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (key_valid || err || num_valid) strobe_seen = 1'b1;
    end
    total++;
    if (strobe_seen !== 1'b0) begin
      bad++;
      $display("FAIL strobe_after_reset got=%b want 0", strobe_seen);
    end
  endtask

  initial begin
    test_reset();
    test_row_scan();
    test_single_key();
    test_overflow();
    test_number();
    test_bad_decode();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_decode.md
KEYPAD_SCAN_DECODE -- requirements
Module: keypad_scan_decode

Interface
REQ-001 Parameter SCAN_DIV, default 27_000, clk cycles per row step (1 ms at 27 MHz); legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 n_reset  input  1  reset, asynchronous, active-low.
REQ-004 db_pulse  input  1  debounced press level from the debouncer; high for its hold window per press.
REQ-005 col_latched  input  4  column captured by the debouncer, active-high, bit0 = leftmost column.
REQ-006 row_out  output  4  keypad row drive, one-hot active-low, bit0 = top row.
REQ-007 key_valid  output  1  one-cycle strobe, key_code valid.
REQ-008 key_code  output  4  decoded key, held until next key_valid.
REQ-009 digits  output  12  BCD entry buffer, digits[11:8] oldest.
REQ-010 num_valid  output  1  one-cycle strobe on '#' entry.
REQ-011 num_value  output  12  BCD value latched at num_valid, held until next num_valid.
REQ-012 err  output  1  one-cycle strobe on decode or overflow error.

Function
REQ-013 Key map (row,col): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: * 0 # D.
REQ-014 Codes: digits 0-9 -> 0x0-0x9, A-D -> 0xA-0xD, '*' -> 0xE, '#' -> 0xF.
REQ-015 Divider counts 0..SCAN_DIV-1 in SCAN; at SCAN_DIV-1 it wraps to 0 and row index advances r0->r1->r2->r3->r0.
REQ-016 row_out = ~(4'b0001 << row_index) at all times after reset.
REQ-017 db_pulse registered into db_q; rising edge = db_pulse & ~db_q at a clk edge.
REQ-018 FSM states SCAN, CAPTURE, EMIT, HOLD.
REQ-019 SCAN: divider/row advance; on rising edge -> CAPTURE; row index and divider frozen from that edge.
REQ-020 CAPTURE (1 cycle): decode frozen row index with col_latched; exactly one bit set -> EMIT; else err=1 for the CAPTURE->HOLD cycle, no key_valid, -> HOLD.
REQ-021 EMIT (1 cycle): key_valid=1, key_code updated, accumulator action applied, -> HOLD.
REQ-022 HOLD: row frozen; when db_pulse=0 -> SCAN, divider resumes from frozen value.
REQ-023 Latency: edge sampled at edge t -> CAPTURE during cycle t+1 -> key_valid high during cycle t+2.
REQ-024 Digit key with count<3: digits <= {digits[7:0], code}, count+1.
REQ-025 Digit key with count=3: digits unchanged, err=1 same cycle as key_valid.
REQ-026 '*': digits <= 0, count <= 0.
REQ-027 '#': num_value <= digits, num_valid=1 same cycle as key_valid, digits <= 0, count <= 0.
REQ-028 '#' with count=0: num_value <= 0x000, num_valid still asserted.
REQ-029 A-D: key_valid only; digits, count, num_value unchanged.
REQ-030 db_pulse already high when reset releases: no edge until it falls and rises again.
REQ-031 db_pulse falling during CAPTURE or EMIT: sequence completes, then HOLD exits to SCAN next cycle.
REQ-032 New rising edge while not in SCAN: ignored.

Reset
REQ-033 n_reset low forces immediately: state SCAN, divider 0, row index 0 (row_out=4'b1110), key_valid=0, key_code=0, digits=0, count=0, num_valid=0, num_value=0, err=0, db_q=1.
REQ-034 Reset mid-sequence (any state) aborts it; no pending strobe after release.

Verification
REQ-035 SCAN_DIV=4, idle 16 cycles -> row_out 1110,1101,1011,0111,1110, each held 4 cycles.
REQ-036 Press during row r1, col_latched=0100 -> key_valid pulse 2 cycles after edge, key_code=0x6, digits=0x006.
REQ-037 Keys 1,2,3,4 -> digits=0x123; '4' gives key_valid+err together, digits stay 0x123.
REQ-038 Keys 4,5,'#' -> num_valid pulse, num_value=0x045, digits=0x000; then '*' -> digits=0x000, no num_valid.
REQ-039 col_latched=0110 on edge -> err pulse, no key_valid, FSM returns to SCAN after db_pulse falls.
REQ-040 n_reset asserted in HOLD with digits=0x012 -> all outputs reset values, row_out=1110, no strobes after release.
